// File: rtl/key_pkg.sv
// Shared types and defaults for the four-key debounce front end.
package key_pkg;

    localparam int NUM_KEYS_DEF = 4;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        HELD          = 2'd2,
        RELEASE_CHECK = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: a four-state FSM that advances only on sample ticks.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = 10
) (
    input  logic clk_in,
    input  logic clr,
    input  logic tick,
    input  logic ks,
    output logic level,
    output logic press_evt
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    key_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (clr) begin
            state <= RELEASED;
            cnt   <= '0;
        end else if (tick) begin
            unique case (state)
                RELEASED: begin
                    if (ks) begin
                        state <= PRESS_CHECK;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_CHECK: begin
                    if (!ks) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!ks) begin
                        state <= RELEASE_CHECK;
                        cnt   <= CW'(1);
                    end
                end
                RELEASE_CHECK: begin
                    if (ks) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // The event is valid only in the tick cycle that moves the FSM into HELD.
    assign press_evt = tick && ks && (state == PRESS_CHECK) && (cnt == LAST);
    assign level     = (state == HELD) || (state == RELEASE_CHECK);

endmodule

// File: rtl/key_debounce.sv
// Key front end: synchroniser, sample prescaler, per-key debounce and press merge.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = NUM_KEYS_DEF,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 10
) (
    input  logic                clk_in,
    input  logic                clr,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic                key_valid,
    output logic [NUM_KEYS-1:0] key_code,
    output logic                key_multi
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] ks;
    logic [NUM_KEYS-1:0] press_evt;
    logic [PW-1:0]       pre;
    logic                tick;
    logic                multi;
    logic                single;

    always_ff @(posedge clk_in) begin
        if (clr) begin
            sync1 <= '0;
            ks    <= '0;
        end else begin
            sync1 <= key_in;
            ks    <= sync1;
        end
    end

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk_in) begin
        if (clr || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_chan (
            .clk_in   (clk_in),
            .clr      (clr),
            .tick     (tick),
            .ks       (ks[i]),
            .level    (key_level[i]),
            .press_evt(press_evt[i])
        );
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi  = |(press_evt & (press_evt - NUM_KEYS'(1)));
    assign single = (|press_evt) && !multi;

    always_ff @(posedge clk_in) begin
        if (clr) begin
            key_valid <= 1'b0;
            key_multi <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= single;
            key_multi <= multi;
            if (single) begin
                key_code <= press_evt;
            end
        end
    end

endmodule
